// File: rtl/anti_theft_fsm.sv
// Anti-theft sequencing controller: arm / trigger / alarm / disarm state machine
// with a loadable 4-bit down-counter advanced by the 1 Hz enable.
module anti_theft_fsm (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_hz_enable,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       reprogram,
    input  logic [3:0] value,
    output logic [1:0] interval,
    output logic       siren,
    output logic       status_led,
    output logic [2:0] state_out
);

    // state             | meaning
    // ARMED             | armed, waiting for a door; LED blinks on ticks
    // TRIGGERED         | door opened while armed; entry delay running
    // ALARM             | siren on; timer restarts while any door is open
    // IGN_ON            | ignition on, system disarmed
    // WAIT_DRV_OPEN     | ignition just turned off, waiting for driver exit
    // WAIT_DOORS_CLOSED | driver door opened, waiting for all doors closed
    // ARM_DELAY         | doors closed, arming delay running
    localparam logic [2:0] ARMED             = 3'b000;
    localparam logic [2:0] TRIGGERED         = 3'b001;
    localparam logic [2:0] ALARM             = 3'b010;
    localparam logic [2:0] IGN_ON            = 3'b011;
    localparam logic [2:0] WAIT_DRV_OPEN     = 3'b100;
    localparam logic [2:0] WAIT_DOORS_CLOSED = 3'b101;
    localparam logic [2:0] ARM_DELAY         = 3'b110;

    localparam logic [1:0] SEL_ARM    = 2'b00;
    localparam logic [1:0] SEL_DRIVER = 2'b01;
    localparam logic [1:0] SEL_PASS   = 2'b10;
    localparam logic [1:0] SEL_ALARM  = 2'b11;

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [3:0] count;
    logic [3:0] count_nxt;
    logic       load;
    logic       load_nxt;
    logic [1:0] interval_nxt;
    logic       led_nxt;
    logic       any_door;
    logic       timed;
    logic       tick;
    logic       expired;

    assign any_door  = door_driver | door_pass;
    assign timed     = (state == TRIGGERED) || (state == ALARM) || (state == ARM_DELAY);
    // The load cycle swallows any tick so that value V always needs V ticks.
    assign tick      = one_hz_enable & ~load;
    assign expired   = tick & (count <= 4'd1);
    assign state_out = state;

    always_comb begin
        count_nxt = count;
        if (load || (state == ALARM && any_door)) begin
            count_nxt = value;
        end else if (timed && tick && (count > 4'd1)) begin
            count_nxt = count - 4'd1;
        end
    end

    always_comb begin
        state_nxt    = state;
        interval_nxt = interval;
        load_nxt     = 1'b0;
        if (reprogram) begin
            state_nxt = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    if (door_driver) begin
                        state_nxt    = TRIGGERED;
                        interval_nxt = SEL_DRIVER;
                        load_nxt     = 1'b1;
                    end else if (door_pass) begin
                        state_nxt    = TRIGGERED;
                        interval_nxt = SEL_PASS;
                        load_nxt     = 1'b1;
                    end
                end
                TRIGGERED: begin
                    if (ignition) begin
                        state_nxt = IGN_ON;
                    end else if (expired) begin
                        state_nxt    = ALARM;
                        interval_nxt = SEL_ALARM;
                        load_nxt     = 1'b1;
                    end
                end
                ALARM: begin
                    if (ignition) begin
                        state_nxt = IGN_ON;
                    end else if (!any_door && expired) begin
                        state_nxt = ARMED;
                    end
                end
                IGN_ON: begin
                    if (!ignition) begin
                        state_nxt = WAIT_DRV_OPEN;
                    end
                end
                WAIT_DRV_OPEN: begin
                    if (ignition) begin
                        state_nxt = IGN_ON;
                    end else if (door_driver) begin
                        state_nxt = WAIT_DOORS_CLOSED;
                    end
                end
                WAIT_DOORS_CLOSED: begin
                    if (ignition) begin
                        state_nxt = IGN_ON;
                    end else if (!any_door) begin
                        state_nxt    = ARM_DELAY;
                        interval_nxt = SEL_ARM;
                        load_nxt     = 1'b1;
                    end
                end
                ARM_DELAY: begin
                    if (ignition) begin
                        state_nxt = IGN_ON;
                    end else if (any_door) begin
                        state_nxt = WAIT_DOORS_CLOSED;
                    end else if (expired) begin
                        state_nxt = ARMED;
                    end
                end
                default: begin
                    state_nxt = ARMED;
                end
            endcase
        end
    end

    // LED blinks only while staying in ARMED; any entry into ARMED starts it dark.
    always_comb begin
        case (state_nxt)
            ARMED:            led_nxt = (state == ARMED && !reprogram) ? (status_led ^ one_hz_enable) : 1'b0;
            TRIGGERED, ALARM: led_nxt = 1'b1;
            default:          led_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ARMED;
            interval   <= SEL_ARM;
            siren      <= 1'b0;
            status_led <= 1'b0;
            count      <= 4'd0;
            load       <= 1'b0;
        end else begin
            state      <= state_nxt;
            interval   <= interval_nxt;
            siren      <= (state_nxt == ALARM);
            status_led <= led_nxt;
            count      <= count_nxt;
            load       <= load_nxt;
        end
    end

endmodule

// File: tb/tb_anti_theft_fsm.sv
// Self-checking bench for anti_theft_fsm: directed scenarios followed by random
// traffic, all compared every cycle against a tick-counting behavioural model.
module tb_anti_theft_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       one_hz_enable = 1'b0;
    logic       ignition = 1'b0;
    logic       door_driver = 1'b0;
    logic       door_pass = 1'b0;
    logic       reprogram = 1'b0;
    logic [3:0] value;
    logic [1:0] interval;
    logic       siren;
    logic       status_led;
    logic [2:0] state_out;

    // time_parameters stand-in: one delay per interval select
    logic [3:0] params [4];
    logic [1:0] prog_sel = 2'd0;
    logic [3:0] prog_val = 4'd0;

    int checks = 0;
    int errors = 0;

    // model: states named by their published encodings
    localparam int M_ARMED = 0, M_TRIG = 1, M_ALARM = 2, M_IGN = 3,
                   M_WDRV = 4, M_WCLOSE = 5, M_ARMDLY = 6;
    int m_state = 0, m_int = 0, m_siren = 0, m_led = 0;
    int m_pend = 0, m_target = 0, m_seen = 0;

    assign value = params[interval];

    anti_theft_fsm dut (
        .clock(clock), .reset(reset), .one_hz_enable(one_hz_enable),
        .ignition(ignition), .door_driver(door_driver), .door_pass(door_pass),
        .reprogram(reprogram), .value(value), .interval(interval),
        .siren(siren), .status_led(status_led), .state_out(state_out)
    );

    always #5 clock = ~clock;

    task automatic defaults();
        params[0] = 4'd6;
        params[1] = 4'd8;
        params[2] = 4'd15;
        params[3] = 4'd10;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Predict one cycle from the rules: a loaded delay V expires on tick max(V,1).
    task automatic model(input bit rst, rp, ign, dd, dp, tk);
        int v, nxt;
        bit door, exp, timed;
        v = int'(params[m_int]);
        door = dd | dp;
        timed = (m_state == M_TRIG) || (m_state == M_ALARM) || (m_state == M_ARMDLY);
        if (rst) begin
            m_state = M_ARMED; m_int = 0; m_siren = 0; m_led = 0;
            m_pend = 0; m_target = 0; m_seen = 0;
        end else if (rp) begin
            m_state = M_ARMED; m_siren = 0; m_led = 0; m_pend = 0;
        end else begin
            exp = 1'b0;
            if (timed && m_pend == 0 && tk && !(m_state == M_ALARM && door)) begin
                m_seen++;
                exp = (m_seen >= m_target);
            end
            if (m_pend != 0 || (m_state == M_ALARM && door)) begin
                m_target = (v == 0) ? 1 : v;
                m_seen = 0;
            end
            m_pend = 0;
            nxt = m_state;
            case (m_state)
                M_ARMED:  if (dd) begin nxt = M_TRIG; m_int = 1; m_pend = 1; end
                          else if (dp) begin nxt = M_TRIG; m_int = 2; m_pend = 1; end
                M_TRIG:   if (ign) nxt = M_IGN;
                          else if (exp) begin nxt = M_ALARM; m_int = 3; m_pend = 1; end
                M_ALARM:  if (ign) nxt = M_IGN; else if (!door && exp) nxt = M_ARMED;
                M_IGN:    if (!ign) nxt = M_WDRV;
                M_WDRV:   if (ign) nxt = M_IGN; else if (dd) nxt = M_WCLOSE;
                M_WCLOSE: if (ign) nxt = M_IGN;
                          else if (!door) begin nxt = M_ARMDLY; m_int = 0; m_pend = 1; end
                M_ARMDLY: if (ign) nxt = M_IGN; else if (door) nxt = M_WCLOSE;
                          else if (exp) nxt = M_ARMED;
                default:  nxt = M_ARMED;
            endcase
            if (nxt == M_ARMED) m_led = (m_state == M_ARMED) ? (m_led ^ int'(tk)) : 0;
            else m_led = (nxt == M_TRIG || nxt == M_ALARM) ? 1 : 0;
            m_siren = (nxt == M_ALARM) ? 1 : 0;
            m_state = nxt;
        end
    endtask

    task automatic step(input bit rst, rp, ign, dd, dp, tk);
        reset = rst; reprogram = rp; ignition = ign;
        door_driver = dd; door_pass = dp; one_hz_enable = tk;
        model(rst, rp, ign, dd, dp, tk);
        @(posedge clock);
        if (rst) defaults();
        else if (rp) params[prog_sel] = prog_val;
        #1;
        check("state", 8'(state_out), 8'(m_state));
        check("interval", 8'(interval), 8'(m_int));
        check("siren", 8'(siren), 8'(m_siren));
        check("led", 8'(status_led), 8'(m_led));
    endtask

    // n ticks, each preceded by three tick-free cycles
    task automatic ticks(input int n, input bit ign, dd, dp);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 3; j++) step(0, 0, ign, dd, dp, 0);
            step(0, 0, ign, dd, dp, 1);
        end
    endtask

    initial begin
        bit r_ign;
        defaults();

        step(1, 0, 0, 0, 0, 0);
        check("rst_state", 8'(state_out), 8'd0);
        check("rst_outs", {4'd0, interval, siren, status_led}, 8'd0);

        // driver door with default 8-tick delay
        step(0, 0, 0, 1, 0, 1);
        check("trig_int", 8'(interval), 8'd1);
        check("trig_led", 8'(status_led), 8'd1);
        ticks(7, 0, 1, 0);
        check("trig_wait", 8'(state_out), 8'd1);
        ticks(1, 0, 1, 0);
        check("alarm_state", 8'(state_out), 8'd2);
        check("alarm_siren", 8'(siren), 8'd1);

        // door held 20 ticks in alarm, then 10 closed ticks
        ticks(20, 0, 1, 0);
        ticks(9, 0, 0, 0);
        check("alarm_hold", 8'(siren), 8'd1);
        ticks(1, 0, 0, 0);
        check("alarm_done", 8'(state_out), 8'd0);
        check("alarm_off", 8'(siren), 8'd0);

        // passenger door, ignition on tick 5
        step(0, 0, 0, 0, 1, 0);
        check("pass_int", 8'(interval), 8'd2);
        ticks(4, 0, 0, 0);
        for (int j = 0; j < 3; j++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        check("ign_win", 8'(state_out), 8'd3);
        check("ign_siren", 8'(siren), 8'd0);

        // disarm / arm-delay sequence
        step(0, 0, 0, 0, 0, 0);
        check("wdrv", 8'(state_out), 8'd4);
        step(0, 0, 0, 1, 0, 0);
        check("wclose", 8'(state_out), 8'd5);
        step(0, 0, 0, 0, 0, 0);
        check("armdly", 8'(state_out), 8'd6);
        check("armdly_int", 8'(interval), 8'd0);
        ticks(2, 0, 0, 0);
        for (int j = 0; j < 3; j++) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        check("armdly_abort", 8'(state_out), 8'd5);
        step(0, 0, 0, 0, 0, 0);
        ticks(5, 0, 0, 0);
        check("armdly_5", 8'(state_out), 8'd6);
        ticks(1, 0, 0, 0);
        check("armdly_6", 8'(state_out), 8'd0);

        // reprogram driver delay to 2
        prog_sel = 2'd1; prog_val = 4'd2;
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        ticks(1, 0, 0, 0);
        check("prog_tick1", 8'(state_out), 8'd1);
        ticks(1, 0, 0, 0);
        check("prog_tick2", 8'(state_out), 8'd2);

        // reset mid-alarm, then LED blinks in ARMED
        step(1, 0, 0, 0, 0, 0);
        check("rst_alarm", {state_out, interval, siren, status_led}, 8'd0);
        ticks(1, 0, 0, 0);
        check("blink_on", 8'(status_led), 8'd1);
        ticks(1, 0, 0, 0);
        check("blink_off", 8'(status_led), 8'd0);

        // zero delay expires on the first tick
        prog_sel = 2'd1; prog_val = 4'd0;
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 1);
        ticks(1, 0, 0, 0);
        check("zero_delay", 8'(state_out), 8'd2);

        // random traffic
        r_ign = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) r_ign = ~r_ign;
            prog_sel = 2'($urandom_range(0, 3));
            prog_val = 4'($urandom_range(0, 15));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 199) == 0, r_ign,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
